// File: rtl/fcond_arbiter_if.sv
// Request/response bundle for fcond_arbiter: two requesters, one result.
// master = requesters + consumer side, slave = arbiter side.
interface fcond_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_x;
  logic [31:0] req0_y;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_x;
  logic [31:0] req1_y;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic        resp_y;
  logic [15:0] busy_cycles;

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_y, busy_cycles
  );

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_y, busy_cycles
  );
endinterface

// File: rtl/fcond_arbiter.sv
// Two-port arbiter in front of a shared float-condition evaluator.
// Ports: clk, rstn (sync, active-high), bus (fcond_arbiter_if.slave).
// Result register holds resp_y/resp_id until resp_ready; busy_cycles
// counts stall cycles (saturating). FCOND_RR_EN selects round-robin
// arbitration; otherwise port 0 has fixed priority.
module fcond_arbiter (
  input logic           clk,
  input logic           rstn,
  fcond_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  state_t      state_nx;
  logic        full;
  logic        load_ok;
  logic        grant0;
  logic        grant1;
  logic        rdy0;
  logic        rdy1;
  logic        accept;
  logic        win_id;
  logic [2:0]  sel_op;
  logic [31:0] sel_x;
  logic [31:0] sel_y;
  logic        eval_y;
  logic        res_id;
  logic        res_y;
  logic [15:0] busy;

  function automatic logic eval(
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic xz;
    logic yz;
    logic eq;
    logic lt;
    xz = (x[30:0] == 31'd0);
    yz = (y[30:0] == 31'd0);
    eq = (x == y) | (xz & yz);
    // Sign-magnitude order; both zeros compare equal.
    if (xz & yz)
      lt = 1'b0;
    else if (x[31] != y[31])
      lt = x[31];
    else if (!x[31])
      lt = (x[30:0] < y[30:0]);
    else
      lt = (x[30:0] > y[30:0]);
    unique case (op)
      3'd0:    eval = (x == 32'd0);
      3'd1:    eval = ~x[31] & ~xz;
      3'd2:    eval = x[31] & ~xz;
      3'd3:    eval = eq;
      3'd4:    eval = lt;
      3'd5:    eval = lt | eq;
      default: eval = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rstn)
      state <= EMPTY;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL: begin
        if (accept)
          state_nx = FULL;
        else if (bus.resp_ready)
          state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    full = (state == FULL);
  end

  assign load_ok = ~full | bus.resp_ready;

`ifdef FCOND_RR_EN
  logic ptr;

  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
    grant1 = bus.req1_valid & (~bus.req0_valid | ptr);
  end

  // Pointer hands preference to the port that did not just win.
  always_ff @(posedge clk) begin
    if (rstn)
      ptr <= 1'b0;
    else if (accept)
      ptr <= ~win_id;
  end
`else
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // No acceptance while reset is held.
  assign rdy0   = ~rstn & load_ok & grant0;
  assign rdy1   = ~rstn & load_ok & grant1;
  assign accept = rdy0 | rdy1;
  assign win_id = rdy1;

  assign sel_op = win_id ? bus.req1_op : bus.req0_op;
  assign sel_x  = win_id ? bus.req1_x  : bus.req0_x;
  assign sel_y  = win_id ? bus.req1_y  : bus.req0_y;
  assign eval_y = eval(sel_op, sel_x, sel_y);

  always_ff @(posedge clk) begin
    if (rstn) begin
      res_id <= 1'b0;
      res_y  <= 1'b0;
    end else if (accept) begin
      res_id <= win_id;
      res_y  <= eval_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn)
      busy <= 16'd0;
    else if (full & ~bus.resp_ready & (busy != 16'hFFFF))
      busy <= busy + 16'd1;
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.resp_valid  = full;
  assign bus.resp_id     = res_id;
  assign bus.resp_y      = res_y;
  assign bus.busy_cycles = busy;

endmodule

// File: tb/tb_fcond_arbiter.sv
// Directed self-checking bench for fcond_arbiter.
// Builds with or without FCOND_RR_EN.
module tb_fcond_arbiter;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  fcond_arbiter_if bus ();

  fcond_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_op    = 3'd0;
    bus.req0_x     = 32'd0;
    bus.req0_y     = 32'd0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 3'd0;
    bus.req1_x     = 32'd0;
    bus.req1_y     = 32'd0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    rstn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready: got %b%b want 00",
               bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_id !== 1'b0 ||
        bus.resp_y !== 1'b0) begin
      n_err++;
      $display("FAIL rst_resp: got v%b id%b y%b want 000",
               bus.resp_valid, bus.resp_id, bus.resp_y);
    end
    n_cmp++;
    if (bus.busy_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL rst_busy: got %0d want 0", bus.busy_cycles);
    end
    rstn = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_ready: got %b want 1", bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unary();
    logic [2:0]  ops [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
    logic [31:0] xs  [5] = '{32'h0, 32'h80000000, 32'h3F800000,
                             32'h80000000, 32'hBF800000};
    logic        exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_op    = ops[i];
      bus.req0_x     = xs[i];
      bus.req0_y     = 32'h12345678;
      #1;
      n_cmp++;
      if (bus.req0_ready !== 1'b1) begin
        n_err++;
        $display("FAIL unary%0d_ready: got %b want 1", i, bus.req0_ready);
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_y !== exp[i] ||
          bus.resp_id !== 1'b0) begin
        n_err++;
        $display("FAIL unary%0d: got v%b y%b id%b want v1 y%b id0",
                 i, bus.resp_valid, bus.resp_y, bus.resp_id, exp[i]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL unary_drain: got %b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_compare();
    logic [2:0]  ops [5] = '{3'd4, 3'd4, 3'd3, 3'd5, 3'd4};
    logic [31:0] xs  [5] = '{32'hBF800000, 32'h40000000, 32'h80000000,
                             32'hC0000000, 32'h80000000};
    logic [31:0] ys  [5] = '{32'h3F800000, 32'h3F800000, 32'h0,
                             32'hBF800000, 32'h0};
    logic        exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req1_valid = 1'b1;
      bus.req1_op    = ops[i];
      bus.req1_x     = xs[i];
      bus.req1_y     = ys[i];
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_y !== exp[i] ||
          bus.resp_id !== 1'b1) begin
        n_err++;
        $display("FAIL cmp%0d: got v%b y%b id%b want v1 y%b id1",
                 i, bus.resp_valid, bus.resp_y, bus.resp_id, exp[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic e_id;
    logic e_r0;
    logic e_r1;
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'd1;
    bus.req0_x     = 32'h3F800000;
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'd2;
    bus.req1_x     = 32'hBF800000;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef FCOND_RR_EN
      e_id = i[0];
`else
      e_id = 1'b0;
`endif
      e_r0 = ~e_id;
      e_r1 = e_id;
      n_cmp++;
      if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) begin
        n_err++;
        $display("FAIL cont%0d_ready: got %b%b want %b%b", i,
                 bus.req0_ready, bus.req1_ready, e_r0, e_r1);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== e_id) begin
        n_err++;
        $display("FAIL cont%0d_id: got v%b id%b want v1 id%b", i,
                 bus.resp_valid, bus.resp_id, e_id);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'd1;
    bus.req0_x     = 32'h3F800000;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req0_op    = 3'd0;
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'd1;
    bus.req1_x     = 32'h3F800000;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.resp_valid !== 1'b1 || bus.resp_y !== 1'b1 ||
          bus.resp_id !== 1'b0 || bus.busy_cycles !== 16'(i)) begin
        n_err++;
        $display("FAIL stall%0d: got r%b%b v%b y%b id%b busy%0d want r00 v1 y1 id0 busy%0d",
                 i, bus.req0_ready, bus.req1_ready, bus.resp_valid,
                 bus.resp_y, bus.resp_id, bus.busy_cycles, i);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.busy_cycles !== 16'd5) begin
      n_err++;
      $display("FAIL busy5: got %0d want 5", bus.busy_cycles);
    end
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got %b want 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 1'b0 ||
        bus.resp_id !== 1'b0 || bus.busy_cycles !== 16'd5) begin
      n_err++;
      $display("FAIL b2b_load: got v%b y%b id%b busy%0d want v1 y0 id0 busy5",
               bus.resp_valid, bus.resp_y, bus.resp_id, bus.busy_cycles);
    end
  endtask

  task automatic test_reset_mid();
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'd0;
    bus.req0_x     = 32'h0;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_ready: got %b want 0", bus.req0_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.busy_cycles !== 16'd0 ||
        bus.req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst: got v%b busy%0d r%b want v0 busy0 r0",
               bus.resp_valid, bus.busy_cycles, bus.req0_ready);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rel_ready: got %b want 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 1'b1 ||
        bus.resp_id !== 1'b0) begin
      n_err++;
      $display("FAIL mid_accept: got v%b y%b id%b want v1 y1 id0",
               bus.resp_valid, bus.resp_y, bus.resp_id);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'd7;
    bus.req0_x     = 32'h0;
    bus.req0_y     = 32'h0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 1'b0 ||
        bus.resp_id !== 1'b0) begin
      n_err++;
      $display("FAIL rsv7: got v%b y%b id%b want v1 y0 id0",
               bus.resp_valid, bus.resp_y, bus.resp_id);
    end
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'd6;
    bus.req1_x     = 32'h0;
    bus.req1_y     = 32'h0;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 1'b0 ||
        bus.resp_id !== 1'b1) begin
      n_err++;
      $display("FAIL rsv6: got v%b y%b id%b want v1 y0 id1",
               bus.resp_valid, bus.resp_y, bus.resp_id);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b1;
    bus.resp_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_unary();
    test_compare();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
